// File: rtl/fpga_pkg.sv
// Shared definitions for the per-test FPGA harness blocks.
// Holds the default out-channel word width and the checker's state encoding.
package fpga_pkg;

  localparam int MemWidthDefault = 12;

  typedef logic [MemWidthDefault-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/out_channel_fifo.sv
// Synchronous receive FIFO for the out channel. Pointers carry one extra wrap bit so that
// full and empty can be told apart; push is allowed at full when a pop happens in the same cycle.
module out_channel_fifo #(
  parameter int Width = 12,
  parameter int Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [Width-1:0] mem_r [Depth];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
    end
  end

  // Word storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/out_channel_checker.sv
// Receiving end of the program out channel: buffers emitted words, compares them in order
// against a loadable expected table and reports finished/success/timeout.
module out_channel_checker
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = MemWidthDefault,
  parameter int NOut               = 2,
  parameter int Depth              = 4,
  parameter int Timeout            = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          expWrite,
  input  logic [$clog2(NOut)-1:0]       expIndex,
  input  logic [MemoryElementWidth-1:0] expData,
  input  logic                          start,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  output logic                          finished,
  output logic                          success,
  output logic [$clog2(NOut+1)-1:0]     received,
  output logic [$clog2(NOut+1)-1:0]     mismatchPos,
  output logic                          timedOut
);

  localparam int IW = $clog2(NOut);
  localparam int CW = $clog2(NOut+1);
  localparam int TW = $clog2(Timeout+1);
  localparam logic [CW-1:0] NOutC    = CW'(NOut);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [TW-1:0] IdleLast = TW'(Timeout-1);
  localparam logic [TW-1:0] IdleOne  = TW'(1);

  state_t                        state_r;
  state_t                        state_next_s;
  logic [MemoryElementWidth-1:0] exp_r [NOut];
  logic [TW-1:0]                 idle_cnt_r;
  logic [MemoryElementWidth-1:0] fifo_rdata_s;
  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic                          push_s;
  logic                          pop_s;
  logic                          xfer_s;
  logic                          cmp_done_s;
  logic                          idle_hit_s;
  logic                          mismatch_s;

  assign outReady   = ((state_r == RUN) && !fifo_full_s) || (state_r == DONE);
  assign finished   = (state_r == DONE);
  assign xfer_s     = outValid && outReady;
  assign cmp_done_s = (received == NOutC);
  assign mismatch_s = (fifo_rdata_s != exp_r[received[IW-1:0]]);

  out_channel_fifo #(
    .Width (MemoryElementWidth),
    .Depth (Depth)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (outData),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Expected table survives reset so a test can be re-run without reloading it
  always_ff @(posedge clock) begin
    if ((state_r == IDLE) && expWrite && (int'(expIndex) < NOut)) begin
      exp_r[expIndex] <= expData;
    end
  end

  // Next-state, FIFO push/pop and timeout decode
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    idle_hit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        push_s = xfer_s;
        pop_s  = !fifo_empty_s && !cmp_done_s;
        if (cmp_done_s) begin
          state_next_s = DONE;
        end else if (!xfer_s && fifo_empty_s && (idle_cnt_r == IdleLast)) begin
          idle_hit_s   = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        // Drain leftovers; words arriving now are accepted and dropped
        pop_s        = !fifo_empty_s;
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register, compare stage, idle counter and result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      received    <= '0;
      mismatchPos <= NOutC;
      success     <= 1'b0;
      timedOut    <= 1'b0;
      idle_cnt_r  <= '0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        RUN: begin
          if (xfer_s) begin
            idle_cnt_r <= '0;
          end else if (fifo_empty_s) begin
            idle_cnt_r <= idle_cnt_r + IdleOne;
          end
          if (pop_s) begin
            received <= received + CntOne;
            if (mismatch_s && (mismatchPos == NOutC)) begin
              mismatchPos <= received;
            end
          end
          // Anything still buffered or arriving on the way into DONE is already an extra
          if (cmp_done_s) begin
            success <= (mismatchPos == NOutC) && fifo_empty_s && !push_s;
          end else if (idle_hit_s) begin
            timedOut <= 1'b1;
            success  <= 1'b0;
          end
        end
        DONE: begin
          if (xfer_s) begin
            success <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
